// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-input stream multiplexer with a one-entry registered
// output stage. The source channel is either chosen explicitly through `sel`
// (MODE=0) or by a round-robin arbiter (MODE=1) whose priority pointer moves
// only when a word is actually accepted.
//
// Handshake: on every port a word moves on a rising edge where valid and
// ready are both high. Valid never waits on ready. in_ready is high for the
// granted channel only, and only while the output register can take a word
// (it is empty, or its word is being taken in the same cycle).
module stream_mux_arb #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int MODE = 0,
  localparam int SW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_chan
);

  logic          can_load;
  logic [SW-1:0] last;
  logic          grant_vld;
  logic [SW-1:0] grant;
  logic [W-1:0]  grant_data;
  logic          xfer;
  int            scan_idx;

  // Output register can accept a new word when empty or draining this cycle.
  always_comb begin
    can_load = !out_valid || out_ready;
  end

  // Pick the granted channel: explicit select, or first valid channel after
  // the last accepted one (wrapping modulo N, also for non-power-of-two N).
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    scan_idx  = 0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        if (in_valid[sel]) begin
          grant_vld = 1'b1;
          grant     = sel;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        scan_idx = int'(last) + k;
        if (scan_idx >= N) scan_idx = scan_idx - N;
        if (!grant_vld && in_valid[scan_idx]) begin
          grant_vld = 1'b1;
          grant     = SW'(scan_idx);
        end
      end
    end
  end

  // One-hot ready towards the granted channel; nothing while in reset.
  always_comb begin
    in_ready = '0;
    if (!rst && can_load && grant_vld) in_ready[grant] = 1'b1;
  end

  // Word accepted from the granted channel this cycle.
  always_comb begin
    xfer = |(in_valid & in_ready);
  end

  // Data of the granted channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == grant) grant_data = in_data[i*W +: W];
    end
  end

  // Output register and round-robin pointer; a load wins over a plain drain,
  // so drain+load in one edge keeps out_valid high at one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= SW'(N - 1);
    end else begin
      if (xfer) begin
        out_data  <= grant_data;
        out_chan  <= grant;
        out_valid <= 1'b1;
        last      <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: explicit-select builds (N=4, N=5) and round-robin
// builds (N=4, N=3) side by side, with directed scenarios and a random run
// against a small behavioural arbiter model feeding an expected-word queue.
module tb_stream_mux_arb;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MODE=0, N=4
  logic [4*W-1:0] s_data;
  logic [3:0]     s_valid, s_rdy;
  logic [1:0]     s_sel, s_chan;
  logic [W-1:0]   s_out;
  logic           s_ov, s_or;
  // MODE=0, N=5
  logic [5*W-1:0] f_data;
  logic [4:0]     f_valid, f_rdy;
  logic [2:0]     f_sel, f_chan;
  logic [W-1:0]   f_out;
  logic           f_ov, f_or;
  // MODE=1, N=4
  logic [4*W-1:0] r_data;
  logic [3:0]     r_valid, r_rdy;
  logic [1:0]     r_sel, r_chan;
  logic [W-1:0]   r_out;
  logic           r_ov, r_or;
  // MODE=1, N=3
  logic [3*W-1:0] t_data;
  logic [2:0]     t_valid, t_rdy;
  logic [1:0]     t_sel, t_chan;
  logic [W-1:0]   t_out;
  logic           t_ov, t_or;

  stream_mux_arb #(.W(W), .N(4), .MODE(0)) u_sel (
    .clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid), .in_ready(s_rdy),
    .sel(s_sel), .out_data(s_out), .out_valid(s_ov), .out_ready(s_or), .out_chan(s_chan));
  stream_mux_arb #(.W(W), .N(5), .MODE(0)) u_sel5 (
    .clk(clk), .rst(rst), .in_data(f_data), .in_valid(f_valid), .in_ready(f_rdy),
    .sel(f_sel), .out_data(f_out), .out_valid(f_ov), .out_ready(f_or), .out_chan(f_chan));
  stream_mux_arb #(.W(W), .N(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(r_data), .in_valid(r_valid), .in_ready(r_rdy),
    .sel(r_sel), .out_data(r_out), .out_valid(r_ov), .out_ready(r_or), .out_chan(r_chan));
  stream_mux_arb #(.W(W), .N(3), .MODE(1)) u_rr3 (
    .clk(clk), .rst(rst), .in_data(t_data), .in_valid(t_valid), .in_ready(t_rdy),
    .sel(t_sel), .out_data(t_out), .out_valid(t_ov), .out_ready(t_or), .out_chan(t_chan));

  // Scoreboard entry: {channel (8 bits), data}
  logic [W+7:0] exp_q[$];
  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic idle_all;
    s_data = '0; s_valid = '0; s_sel = '0; s_or = 1'b0;
    f_data = '0; f_valid = '0; f_sel = '0; f_or = 1'b0;
    r_data = '0; r_valid = '0; r_sel = '0; r_or = 1'b0;
    t_data = '0; t_valid = '0; t_sel = '0; t_or = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    s_valid = '1; f_valid = '1; r_valid = '1; t_valid = '1;
    s_or = 1'b1; f_or = 1'b1; r_or = 1'b1; t_or = 1'b1;
    #1;
    check_cnt++;
    if ({s_rdy, f_rdy, r_rdy, t_rdy} !== 16'h0)
      $display("FAIL reset_in_ready got=%b exp=0", {s_rdy, f_rdy, r_rdy, t_rdy});
    else pass_cnt++;
    @(negedge clk);
    #1;
    check_cnt++;
    if ({s_ov, f_ov, r_ov, t_ov} !== 4'b0000)
      $display("FAIL reset_out_valid got=%b exp=0000", {s_ov, f_ov, r_ov, t_ov});
    else pass_cnt++;
    check_cnt++;
    if (s_out !== '0 || r_out !== '0 || s_chan !== 2'd0 || r_chan !== 2'd0)
      $display("FAIL reset_out_regs got=%h/%h chan=%0d/%0d exp=0", s_out, r_out, s_chan, r_chan);
    else pass_cnt++;
    rst = 1'b0;
    idle_all();
  endtask

  task automatic test_sel_basic;
    logic [W+7:0] e;
    do_reset();
    @(negedge clk);
    s_sel = 2'd2; s_valid = 4'b0100; s_or = 1'b1;
    s_data = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    #1;
    check_cnt++;
    if (s_rdy !== 4'b0100) $display("FAIL sel_basic_ready got=%b exp=0100", s_rdy);
    else pass_cnt++;
    exp_q.push_back({8'd2, 32'hDEADBEEF});
    @(negedge clk);
    s_valid = '0;
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if (s_ov !== 1'b1 || s_out !== e[W-1:0] || 8'(s_chan) !== e[W+7:W])
      $display("FAIL sel_basic_out got=%b/%h/%0d exp=1/%h/%0d", s_ov, s_out, s_chan, e[W-1:0], e[W+7:W]);
    else pass_cnt++;
    @(negedge clk);
    #1;
    check_cnt++;
    if (s_ov !== 1'b0 || s_out !== 32'hDEADBEEF || s_chan !== 2'd2)
      $display("FAIL sel_drain got=%b/%h/%0d exp=0/deadbeef/2", s_ov, s_out, s_chan);
    else pass_cnt++;
  endtask

  task automatic test_sel_range;
    logic [W+7:0] e;
    do_reset();
    @(negedge clk);
    f_sel = 3'd5; f_valid = '1; f_or = 1'b1;
    for (int i = 0; i < 5; i++) f_data[i*W +: W] = 32'hF000 + i;
    s_sel = 2'd3; s_valid = 4'b0111; s_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_cnt++;
      if (f_rdy !== 5'b0 || f_ov !== 1'b0)
        $display("FAIL sel_out_of_range k=%0d got=%b/%b exp=00000/0", k, f_rdy, f_ov);
      else pass_cnt++;
      check_cnt++;
      if (s_rdy !== 4'b0 || s_ov !== 1'b0)
        $display("FAIL sel_invalid_chan k=%0d got=%b/%b exp=0000/0", k, s_rdy, s_ov);
      else pass_cnt++;
      @(negedge clk);
      if (k == 1) f_sel = 3'd7;
    end
    f_sel = 3'd4;
    #1;
    check_cnt++;
    if (f_rdy !== 5'b10000) $display("FAIL sel_top_chan_ready got=%b exp=10000", f_rdy);
    else pass_cnt++;
    exp_q.push_back({8'd4, f_data[4*W +: W]});
    @(negedge clk);
    f_valid = '0;
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if (f_ov !== 1'b1 || f_out !== e[W-1:0] || 8'(f_chan) !== e[W+7:W])
      $display("FAIL sel_top_chan_out got=%b/%h/%0d exp=1/%h/%0d", f_ov, f_out, f_chan, e[W-1:0], e[W+7:W]);
    else pass_cnt++;
  endtask

  task automatic test_sel_stall_change;
    logic [W+7:0] e;
    do_reset();
    @(negedge clk);
    s_sel = 2'd1; s_valid = 4'b1010; s_or = 1'b1;
    s_data = {32'hC3C3C3C3, 32'h0, 32'hC1C1C1C1, 32'h0};
    #1;
    check_cnt++;
    if (s_rdy !== 4'b0010) $display("FAIL stall_first_ready got=%b exp=0010", s_rdy);
    else pass_cnt++;
    exp_q.push_back({8'd1, 32'hC1C1C1C1});
    @(negedge clk);
    s_or = 1'b0; s_sel = 2'd3;
    for (int k = 0; k < 2; k++) begin
      #1;
      e = exp_q[0];
      check_cnt++;
      if (s_rdy !== 4'b0 || s_ov !== 1'b1 || s_out !== e[W-1:0] || 8'(s_chan) !== e[W+7:W])
        $display("FAIL stall_hold k=%0d got=%b/%b/%h/%0d exp=0000/1/%h/%0d", k, s_rdy, s_ov, s_out, s_chan, e[W-1:0], e[W+7:W]);
      else pass_cnt++;
      @(negedge clk);
    end
    s_or = 1'b1;
    #1;
    check_cnt++;
    if (s_rdy !== 4'b1000) $display("FAIL stall_new_sel_ready got=%b exp=1000", s_rdy);
    else pass_cnt++;
    e = exp_q.pop_front();
    check_cnt++;
    if (s_out !== e[W-1:0] || 8'(s_chan) !== e[W+7:W])
      $display("FAIL stall_drain_word got=%h/%0d exp=%h/%0d", s_out, s_chan, e[W-1:0], e[W+7:W]);
    else pass_cnt++;
    exp_q.push_back({8'd3, 32'hC3C3C3C3});
    @(negedge clk);
    s_valid = '0;
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if (s_ov !== 1'b1 || s_out !== e[W-1:0] || 8'(s_chan) !== e[W+7:W])
      $display("FAIL stall_next_word got=%b/%h/%0d exp=1/%h/%0d", s_ov, s_out, s_chan, e[W-1:0], e[W+7:W]);
    else pass_cnt++;
    @(negedge clk);
    #1;
    check_cnt++;
    if (s_ov !== 1'b0) $display("FAIL stall_no_dup got=%b exp=0", s_ov);
    else pass_cnt++;
  endtask

  task automatic test_rr_rotation;
    logic [W+7:0] e;
    do_reset();
    @(negedge clk);
    r_valid = 4'hF; r_or = 1'b1;
    for (int i = 0; i < 4; i++) r_data[i*W +: W] = 32'hA0 + i;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k > 0) begin
        e = exp_q.pop_front();
        check_cnt++;
        if (r_ov !== 1'b1 || r_out !== e[W-1:0] || 8'(r_chan) !== e[W+7:W])
          $display("FAIL rr_rotation_out k=%0d got=%b/%h/%0d exp=1/%h/%0d", k, r_ov, r_out, r_chan, e[W-1:0], e[W+7:W]);
        else pass_cnt++;
      end
      if (k < 5) begin
        check_cnt++;
        if (r_rdy !== 4'(1 << (k % 4)))
          $display("FAIL rr_rotation_ready k=%0d got=%b exp=%b", k, r_rdy, 4'(1 << (k % 4)));
        else pass_cnt++;
        exp_q.push_back({8'(k % 4), 32'hA0 + 32'(k % 4)});
      end
      @(negedge clk);
    end
    r_valid = '0;
  endtask

  task automatic test_rr3_stall;
    logic [W+7:0] e;
    do_reset();
    @(negedge clk);
    t_valid = 3'b101; t_or = 1'b1;
    t_data = {32'h33, 32'h22, 32'h11};
    #1;
    check_cnt++;
    if (t_rdy !== 3'b001) $display("FAIL rr3_first_ready got=%b exp=001", t_rdy);
    else pass_cnt++;
    exp_q.push_back({8'd0, 32'h11});
    @(negedge clk);
    t_or = 1'b0;
    t_data[0 +: W] = 32'h55;
    for (int k = 0; k < 3; k++) begin
      #1;
      e = exp_q[0];
      check_cnt++;
      if (t_rdy !== 3'b0 || t_ov !== 1'b1 || t_out !== e[W-1:0] || 8'(t_chan) !== e[W+7:W])
        $display("FAIL rr3_hold k=%0d got=%b/%b/%h/%0d exp=000/1/%h/%0d", k, t_rdy, t_ov, t_out, t_chan, e[W-1:0], e[W+7:W]);
      else pass_cnt++;
      @(negedge clk);
    end
    t_or = 1'b1;
    #1;
    check_cnt++;
    if (t_rdy !== 3'b100) $display("FAIL rr3_after_stall_ready got=%b exp=100", t_rdy);
    else pass_cnt++;
    void'(exp_q.pop_front());
    exp_q.push_back({8'd2, 32'h33});
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if (t_ov !== 1'b1 || t_out !== e[W-1:0] || 8'(t_chan) !== e[W+7:W])
      $display("FAIL rr3_chan2 got=%b/%h/%0d exp=1/%h/%0d", t_ov, t_out, t_chan, e[W-1:0], e[W+7:W]);
    else pass_cnt++;
    check_cnt++;
    if (t_rdy !== 3'b001) $display("FAIL rr3_wrap_ready got=%b exp=001", t_rdy);
    else pass_cnt++;
    exp_q.push_back({8'd0, 32'h55});
    @(negedge clk);
    t_valid = '0;
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if (t_ov !== 1'b1 || t_out !== e[W-1:0] || 8'(t_chan) !== e[W+7:W])
      $display("FAIL rr3_chan0 got=%b/%h/%0d exp=1/%h/%0d", t_ov, t_out, t_chan, e[W-1:0], e[W+7:W]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [W+7:0] e;
    do_reset();
    @(negedge clk);
    r_valid = 4'b0100; r_or = 1'b1;
    r_data = '0;
    r_data[2*W +: W] = 32'h12345678;
    #1;
    exp_q.push_back({8'd2, 32'h12345678});
    @(negedge clk);
    r_valid = '0; r_or = 1'b0;
    #1;
    e = exp_q[0];
    check_cnt++;
    if (r_ov !== 1'b1 || r_out !== e[W-1:0] || 8'(r_chan) !== e[W+7:W])
      $display("FAIL midrst_loaded got=%b/%h/%0d exp=1/%h/%0d", r_ov, r_out, r_chan, e[W-1:0], e[W+7:W]);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_cnt++;
    if (r_ov !== 1'b0 || r_out !== '0 || r_chan !== 2'd0)
      $display("FAIL midrst_cleared got=%b/%h/%0d exp=0/0/0", r_ov, r_out, r_chan);
    else pass_cnt++;
    r_valid = 4'hF; r_or = 1'b1;
    for (int i = 0; i < 4; i++) r_data[i*W +: W] = 32'hB0 + i;
    #1;
    check_cnt++;
    if (r_rdy !== 4'b0001) $display("FAIL midrst_first_grant got=%b exp=0001", r_rdy);
    else pass_cnt++;
    exp_q.push_back({8'd0, 32'hB0});
    @(negedge clk);
    r_valid = '0;
    #1;
    e = exp_q.pop_front();
    check_cnt++;
    if (r_ov !== 1'b1 || r_out !== e[W-1:0] || 8'(r_chan) !== e[W+7:W])
      $display("FAIL midrst_first_word got=%b/%h/%0d exp=1/%h/%0d", r_ov, r_out, r_chan, e[W-1:0], e[W+7:W]);
    else pass_cnt++;
  endtask

  task automatic test_random;
    int m_last;
    bit m_ov;
    bit found;
    int g;
    int c;
    logic [3:0] exp_rdy;
    logic [W+7:0] e;
    do_reset();
    m_last = 3;
    m_ov = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      r_valid = 4'($urandom_range(0, 15));
      r_or = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) r_data[i*W +: W] = $urandom;
      #1;
      found = 1'b0;
      g = 0;
      if (!m_ov || r_or) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (!found && r_valid[c]) begin
            found = 1'b1;
            g = c;
          end
        end
      end
      exp_rdy = found ? 4'(1 << g) : 4'b0;
      check_cnt++;
      if (r_rdy !== exp_rdy)
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, r_rdy, exp_rdy);
      else pass_cnt++;
      check_cnt++;
      if (r_ov !== m_ov)
        $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, r_ov, m_ov);
      else pass_cnt++;
      if (m_ov && r_or) begin
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_out_word cyc=%0d got=%h/%0d exp=none", cyc, r_out, r_chan);
        end else begin
          e = exp_q.pop_front();
          if (r_out !== e[W-1:0] || 8'(r_chan) !== e[W+7:W])
            $display("FAIL rand_out_word cyc=%0d got=%h/%0d exp=%h/%0d", cyc, r_out, r_chan, e[W-1:0], e[W+7:W]);
          else pass_cnt++;
        end
      end
      if (found) begin
        exp_q.push_back({8'(g), r_data[g*W +: W]});
        m_last = g;
        m_ov = 1'b1;
      end else if (r_or) begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
    r_valid = '0;
    r_or = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_sel_basic();
    test_sel_range();
    test_sel_stall_change();
    test_rr_rotation();
    test_rr3_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
